cc_collision_scanner: RTL and testbench
=======================================

Name: cc_collision_scanner

Overview:
- Parametrised, registered successor to the combinational alien/bullet row comparator in the Space Invaders datapath.
- On a start strobe, snapshots the alien, bullet and ship matrices, then scans rows 1..ROWS-1 one per clock.
- Reports first-hit row and column mask, a sticky lose flag (enemy bullet on the ship row) and a bullet-ready flag.
- Sits between the matrix joiner and the game-control FSM; fires once per game tick.

Parameters:
- ROWS, 8, matrix rows; row 0 is the ship row (min 2)
- COLS, 8, matrix columns, i.e. row width in bits
- ROW_W, 3, width of the row index; ROW_W >= clog2(ROWS)
- SCORE_W, 8, score counter width; used only with CC_COLLISION_SCORE_EN

Ports:
- CC_COLLISION_CLOCK_50  in  1  system clock, all state on the rising edge
- CC_COLLISION_RESET_InHigh  in  1  asynchronous, active-high reset
- CC_COLLISION_start_in  in  1  frame scan request, single-cycle strobe
- CC_COLLISION_clearlose_in  in  1  clears the sticky lose flag
- CC_COLLISION_aliens_bus_in  in  ROWS*COLS  alien matrix, row r at bits [r*COLS +: COLS]
- CC_COLLISION_bullet_bus_in  in  ROWS*COLS  bullet matrix, same packing
- CC_COLLISION_ship_bus_in  in  COLS  ship occupancy on row 0
- CC_COLLISION_busy  out  1  high from the cycle after start until done
- CC_COLLISION_done  out  1  one-cycle pulse when frame results are valid
- CC_COLLISION_hit  out  1  an alien/bullet overlap was found in the last frame
- CC_COLLISION_hitrow  out  ROW_W  lowest-index row with an overlap
- CC_COLLISION_hitmask  out  COLS  overlap columns in hitrow
- CC_COLLISION_lose  out  1  sticky: bullet overlaps ship on row 0
- CC_COLLISION_statebullet  out  1  high when a new player bullet may be fired

Behaviour:
- FSM states: IDLE, SCAN, DONE.
- Reset, asynchronous and at any time including mid-SCAN:
  - state=IDLE, row counter=1, snapshots=0
  - busy=0, done=0, hit=0, hitrow=0, hitmask=0, lose=0, statebullet=1
- IDLE, start=1:
  - Register the aliens and bullet matrices into snapshot registers; the inputs may change afterwards.
  - Clear the internal frame-hit accumulators and set row counter=1; go to SCAN.
  - If (bullet row0 & ship) != 0, set lose=1.
  - start is ignored outside IDLE, with no queuing.
- SCAN, one row per cycle, r = counter:
  - ov = alien_snap[r] & bullet_snap[r].
  - If ov != 0 and no hit has been recorded yet this frame, record r and ov. The lowest row wins; later rows are ignored.
  - If bullet_snap[r] != 0, set the internal bullet_seen flag.
  - If r == ROWS-1, go to DONE; otherwise increment r.
- DONE, one cycle:
  - done=1.
  - hit, hitrow and hitmask update from the accumulators and hold until the next DONE.
  - statebullet = (!bullet_seen) | frame_hit.
  - Return to IDLE.
- Latency: start sampled at edge N; done high during the cycle after edge N+ROWS; busy high for ROWS cycles.
- A frame with no overlap gives hit=0, hitrow=0, hitmask=0.
- A bullet in row 0 is ignored by the hit and bullet_seen logic.
- clearlose=1 clears lose. If a lose-set and clearlose occur on the same edge, set wins.
- Arithmetic: the row counter is ROW_W bits, counts 1..ROWS-1 and never wraps inside a frame.

Optional Feature:
- CC_COLLISION_SCORE_EN defined:
  - Adds output CC_COLLISION_score (SCORE_W bits, reset 0).
  - In DONE, score += popcount(hitmask), saturating at 2^SCORE_W-1.
  - Cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- ROWS=8, COLS=8. Reset mid-SCAN (assert at 3rd SCAN cycle) -> all outputs return to reset values immediately; next start runs a full 8-cycle frame.
- aliens row3=8'h18, bullet row3=8'h10, start -> busy for 8 cycles, done pulse 8 cycles after start; hit=1, hitrow=3, hitmask=8'h10, statebullet=1.
- Overlaps in row2 (8'h01) and row5 (8'h80) -> hitrow=2, hitmask=8'h01. Score +1 with SCORE_EN.
- Bullet only in row6=8'h04, aliens elsewhere -> hit=0, statebullet=0. Empty bullet matrix -> statebullet=1.
- bullet row0=8'h20, ship=8'h20 -> lose=1 after start, held across frames. clearlose on the same edge as a new set keeps lose=1; clearlose alone clears it.
- Start pulsed during busy, and input matrices changed mid-frame -> second start ignored; results reflect the snapshot taken at the first start.

Source files
------------

// File: rtl/cc_collision_scanner.sv
// Registered alien/bullet collision scanner: snapshots the matrices on start and scans rows 1..ROWS-1, one per clock.
// Optional score output is enabled by defining CC_COLLISION_SCORE_EN.
module cc_collision_scanner #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int ROW_W   = 3,
    parameter int SCORE_W = 8
) (
    input  logic                   CC_COLLISION_CLOCK_50,
    input  logic                   CC_COLLISION_RESET_InHigh,
    input  logic                   CC_COLLISION_start_in,
    input  logic                   CC_COLLISION_clearlose_in,
    input  logic [ROWS*COLS-1:0]   CC_COLLISION_aliens_bus_in,
    input  logic [ROWS*COLS-1:0]   CC_COLLISION_bullet_bus_in,
    input  logic [COLS-1:0]        CC_COLLISION_ship_bus_in,
    output logic                   CC_COLLISION_busy,
    output logic                   CC_COLLISION_done,
    output logic                   CC_COLLISION_hit,
    output logic [ROW_W-1:0]       CC_COLLISION_hitrow,
    output logic [COLS-1:0]        CC_COLLISION_hitmask,
    output logic                   CC_COLLISION_lose,
    output logic                   CC_COLLISION_statebullet
`ifdef CC_COLLISION_SCORE_EN
    ,output logic [SCORE_W-1:0]    CC_COLLISION_score
`endif
);

    if (ROWS < 2 || COLS < 1 || ROW_W < $clog2(ROWS) || SCORE_W < 1) begin : g_cfg_check
        $error("cc_collision_scanner: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 r_state, w_next;
    logic [ROW_W-1:0]       r_row;
    logic [ROWS*COLS-1:0]   r_asnap, r_bsnap;
    logic                   r_fhit, r_bseen;
    logic [ROW_W-1:0]       r_frow;
    logic [COLS-1:0]        r_fmask;

    logic                   w_start_ok, w_last, w_lose_set;
    logic [COLS-1:0]        w_arow, w_brow, w_ov;

    assign w_start_ok = CC_COLLISION_start_in && (r_state == IDLE);
    assign w_last     = (r_row == ROW_W'(ROWS - 1));
    assign w_arow     = r_asnap[r_row*COLS +: COLS];
    assign w_brow     = r_bsnap[r_row*COLS +: COLS];
    assign w_ov       = w_arow & w_brow;
    // Ship row is checked against the live bus at the start edge, not the snapshot.
    assign w_lose_set = w_start_ok && |(CC_COLLISION_bullet_bus_in[COLS-1:0] & CC_COLLISION_ship_bus_in);

    assign CC_COLLISION_busy = (r_state != IDLE);

    always_ff @(posedge CC_COLLISION_CLOCK_50 or posedge CC_COLLISION_RESET_InHigh) begin
        if (CC_COLLISION_RESET_InHigh) r_state <= IDLE;
        else                           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (CC_COLLISION_start_in) w_next = SCAN;
            SCAN:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef CC_COLLISION_SCORE_EN
    function automatic int unsigned popcount(input logic [COLS-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < COLS; i++) n += 32'(v[i]);
        return n;
    endfunction

    logic [SCORE_W:0] w_sum;
    assign w_sum = {1'b0, CC_COLLISION_score} + (SCORE_W+1)'(popcount(r_fmask));

    always_ff @(posedge CC_COLLISION_CLOCK_50 or posedge CC_COLLISION_RESET_InHigh) begin
        if (CC_COLLISION_RESET_InHigh)
            CC_COLLISION_score <= '0;
        else if (r_state == DONE)
            CC_COLLISION_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
    end
`endif

    always_ff @(posedge CC_COLLISION_CLOCK_50 or posedge CC_COLLISION_RESET_InHigh) begin
        if (CC_COLLISION_RESET_InHigh) begin
            r_row                    <= ROW_W'(1);
            r_asnap                  <= '0;
            r_bsnap                  <= '0;
            r_fhit                   <= 1'b0;
            r_bseen                  <= 1'b0;
            r_frow                   <= '0;
            r_fmask                  <= '0;
            CC_COLLISION_done        <= 1'b0;
            CC_COLLISION_hit         <= 1'b0;
            CC_COLLISION_hitrow      <= '0;
            CC_COLLISION_hitmask     <= '0;
            CC_COLLISION_lose        <= 1'b0;
            CC_COLLISION_statebullet <= 1'b1;
        end else begin
            CC_COLLISION_done <= 1'b0;
            if (w_lose_set)
                CC_COLLISION_lose <= 1'b1;
            else if (CC_COLLISION_clearlose_in)
                CC_COLLISION_lose <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (CC_COLLISION_start_in) begin
                        r_asnap <= CC_COLLISION_aliens_bus_in;
                        r_bsnap <= CC_COLLISION_bullet_bus_in;
                        r_fhit  <= 1'b0;
                        r_bseen <= 1'b0;
                        r_frow  <= '0;
                        r_fmask <= '0;
                        r_row   <= ROW_W'(1);
                    end
                end
                SCAN: begin
                    if (|w_ov && !r_fhit) begin
                        r_fhit  <= 1'b1;
                        r_frow  <= r_row;
                        r_fmask <= w_ov;
                    end
                    if (|w_brow) r_bseen <= 1'b1;
                    if (!w_last) r_row <= r_row + 1'b1;
                end
                DONE: begin
                    CC_COLLISION_done        <= 1'b1;
                    CC_COLLISION_hit         <= r_fhit;
                    CC_COLLISION_hitrow      <= r_frow;
                    CC_COLLISION_hitmask     <= r_fmask;
                    CC_COLLISION_statebullet <= !r_bseen || r_fhit;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_collision_scanner.sv
// Scoreboard bench for cc_collision_scanner (ROWS=8, COLS=8); define CC_COLLISION_SCORE_EN to also check the score.
module tb_cc_collision_scanner;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 clearlose = 1'b0;
    logic [ROWS*COLS-1:0] aliens = '0;
    logic [ROWS*COLS-1:0] bullet = '0;
    logic [COLS-1:0]      ship = '0;
    logic                 busy, done, hit, lose, statebullet;
    logic [2:0]           hitrow;
    logic [COLS-1:0]      hitmask;
`ifdef CC_COLLISION_SCORE_EN
    logic [7:0]           score;
    int                   exp_score = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_lose = 1'b0;

    typedef struct {
        logic       hit;
        logic [2:0] row;
        logic [7:0] mask;
        logic       sb;
    } exp_t;
    exp_t sb_q[$];

    cc_collision_scanner #(.ROWS(ROWS), .COLS(COLS), .ROW_W(3), .SCORE_W(8)) dut (
        .CC_COLLISION_CLOCK_50(clk),
        .CC_COLLISION_RESET_InHigh(rst),
        .CC_COLLISION_start_in(start),
        .CC_COLLISION_clearlose_in(clearlose),
        .CC_COLLISION_aliens_bus_in(aliens),
        .CC_COLLISION_bullet_bus_in(bullet),
        .CC_COLLISION_ship_bus_in(ship),
        .CC_COLLISION_busy(busy),
        .CC_COLLISION_done(done),
        .CC_COLLISION_hit(hit),
        .CC_COLLISION_hitrow(hitrow),
        .CC_COLLISION_hitmask(hitmask),
        .CC_COLLISION_lose(lose),
        .CC_COLLISION_statebullet(statebullet)
`ifdef CC_COLLISION_SCORE_EN
        , .CC_COLLISION_score(score)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [ROWS*COLS-1:0] a, input logic [ROWS*COLS-1:0] b);
        exp_t e;
        logic seen;
        logic [COLS-1:0] ov;
        e.hit = 1'b0; e.row = '0; e.mask = '0; seen = 1'b0;
        for (int r = 1; r < ROWS; r++) begin
            ov = a[r*COLS +: COLS] & b[r*COLS +: COLS];
            if (ov != 0 && !e.hit) begin
                e.hit = 1'b1; e.row = 3'(r); e.mask = ov;
            end
            if (b[r*COLS +: COLS] != 0) seen = 1'b1;
        end
        e.sb = !seen || e.hit;
        return e;
    endfunction

    function automatic logic [ROWS*COLS-1:0] rowv(input int r, input logic [COLS-1:0] v);
        logic [ROWS*COLS-1:0] m;
        m = '0;
        m[r*COLS +: COLS] = v;
        return m;
    endfunction

    task automatic run_frame(input logic [ROWS*COLS-1:0] a, input logic [ROWS*COLS-1:0] b,
                             input logic [COLS-1:0] sh, input logic clr, input logic mutate);
        exp_t e;
        int cycles, busycnt;
        @(negedge clk);
        aliens = a; bullet = b; ship = sh; start = 1'b1; clearlose = clr;
        sb_q.push_back(model(a, b));
        if ((b[COLS-1:0] & sh) != 0) exp_lose = 1'b1;
        else if (clr)                exp_lose = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; clearlose = 1'b0;
        n_checks++;
        if (lose !== exp_lose) begin
            n_fail++; $display("FAIL lose_at_start: got %b expected %b", lose, exp_lose);
        end
        cycles = 0; busycnt = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (busy === 1'b1) busycnt++;
            if (mutate && cycles == 2) begin
                aliens = '1; bullet = '1; start = 1'b1;
            end
            if (mutate && cycles == 3) start = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL done_timeout: got %b expected 1 within 20 cycles", done);
        end
        n_checks++;
        if (cycles != ROWS) begin
            n_fail++; $display("FAIL done_latency: got %0d expected %0d", cycles, ROWS);
        end
        n_checks++;
        if (busycnt != ROWS) begin
            n_fail++; $display("FAIL busy_cycles: got %0d expected %0d", busycnt, ROWS);
        end
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if (hit !== e.hit) begin
                n_fail++; $display("FAIL hit: got %b expected %b", hit, e.hit);
            end
            n_checks++;
            if (hitrow !== e.row) begin
                n_fail++; $display("FAIL hitrow: got %0d expected %0d", hitrow, e.row);
            end
            n_checks++;
            if (hitmask !== e.mask) begin
                n_fail++; $display("FAIL hitmask: got %h expected %h", hitmask, e.mask);
            end
            n_checks++;
            if (statebullet !== e.sb) begin
                n_fail++; $display("FAIL statebullet: got %b expected %b", statebullet, e.sb);
            end
`ifdef CC_COLLISION_SCORE_EN
            for (int i = 0; i < COLS; i++) exp_score += int'(e.mask[i]);
            if (exp_score > 255) exp_score = 255;
            n_checks++;
            if (score !== 8'(exp_score)) begin
                n_fail++; $display("FAIL score: got %0d expected %0d", score, exp_score);
            end
`endif
        end
        n_checks++;
        if (lose !== exp_lose) begin
            n_fail++; $display("FAIL lose_held: got %b expected %b", lose, exp_lose);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_done: got done=%b busy=%b expected done=0 busy=0", done, busy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || hitrow !== 3'd0 ||
            hitmask !== 8'h00 || lose !== 1'b0 || statebullet !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b hit=%b row=%0d mask=%h lose=%b sb=%b expected 0 0 0 0 00 0 1",
                     tag, busy, done, hit, hitrow, hitmask, lose, statebullet);
        end
`ifdef CC_COLLISION_SCORE_EN
        n_checks++;
        if (score !== 8'd0) begin
            n_fail++; $display("FAIL %s_score: got %0d expected 0", tag, score);
        end
`endif
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        check_reset_values("reset_state");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_hit();
        run_frame(rowv(3, 8'h18), rowv(3, 8'h10), 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_lowest_row();
        run_frame(rowv(2, 8'h01) | rowv(5, 8'h80), rowv(2, 8'h01) | rowv(5, 8'h80), 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_bullet_only();
        run_frame(rowv(1, 8'hFF) | rowv(4, 8'h3C), rowv(6, 8'h04), 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        run_frame(rowv(2, 8'hAA) | rowv(7, 8'h55), '0, 8'h00, 1'b0, 1'b0);
        // row-0 overlap must not count as a hit or a seen bullet
        run_frame(rowv(0, 8'hFF), rowv(0, 8'hFF), 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_lose();
        run_frame(rowv(4, 8'h0F), rowv(0, 8'h20), 8'h20, 1'b0, 1'b0);
        run_frame(rowv(4, 8'h0F), rowv(4, 8'h01), 8'h20, 1'b0, 1'b0);
        run_frame('0, rowv(0, 8'h20), 8'h20, 1'b1, 1'b0);
        @(negedge clk);
        clearlose = 1'b1;
        @(posedge clk); #1;
        clearlose = 1'b0;
        exp_lose = 1'b0;
        n_checks++;
        if (lose !== 1'b0) begin
            n_fail++; $display("FAIL clearlose_alone: got %b expected 0", lose);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(rowv(3, 8'h18), rowv(3, 8'h10) | rowv(6, 8'h40), 8'h00, 1'b0, 1'b1);
        run_frame(rowv(7, 8'hC0), rowv(7, 8'h40), 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midscan();
        run_frame(rowv(5, 8'h22), rowv(0, 8'h01) | rowv(5, 8'h02), 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        aliens = rowv(1, 8'hFF); bullet = rowv(1, 8'hFF); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_values("reset_midscan");
        exp_lose = 1'b0;
`ifdef CC_COLLISION_SCORE_EN
        exp_score = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        run_frame(rowv(6, 8'h81), rowv(6, 8'h80), 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_hit();
        test_lowest_row();
        test_bullet_only();
        test_empty();
        test_lose();
        test_back_to_back();
        test_reset_midscan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
